// File: rtl/mem_lock_arbiter.sv
// Round-robin arbiter that shares one main memory port and an L-entry hardware
// lock table among C cores; memory and lock grants use independent pointers.
module mem_lock_arbiter #(
   parameter int C = 8,
   parameter int L = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [C-1:0]              main_mem_read_request,
   input  logic [C-1:0]              main_mem_write_request,
   input  logic [C*16-1:0]           main_mem_read_adr,
   input  logic [C*16-1:0]           main_mem_write_adr,
   input  logic [C*16-1:0]           main_mem_write_dat,
   output logic [C-1:0]              main_mem_ac,
   output logic [15:0]               mem_adr,
   output logic                      mem_we,
   output logic                      mem_re,
   output logic [15:0]               mem_wdat,
   input  logic [C*$clog2(L)-1:0]    lock_adr,
   input  logic [C-1:0]              lock_en,
   input  logic [C-1:0]              unlock_en,
   output logic [C-1:0]              lock_ac,
   output logic [L-1:0]              lock_busy,
   output logic                      lock_err
);

   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam int LW = $clog2(L);

   logic [C-1:0][15:0]   rd_adr_v, wr_adr_v, wr_dat_v;
   logic [C-1:0][LW-1:0] lk_adr_v;

   assign rd_adr_v = main_mem_read_adr;
   assign wr_adr_v = main_mem_write_adr;
   assign wr_dat_v = main_mem_write_dat;
   assign lk_adr_v = lock_adr;

   // Returns {found, index}: first set request at or after ptr, wrapping.
   function automatic logic [CW:0] rr_pick(input logic [C-1:0] req, input logic [CW-1:0] ptr);
      logic [C-1:0] rot;
      logic         found;
      int           off;
      int           s;
      rot   = (req >> ptr) | (req << (C - int'(ptr)));
      found = 1'b0;
      off   = 0;
      for (int k = C - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      s = int'(ptr) + off;
      if (s >= C) s = s - C;
      return {found, CW'(s)};
   endfunction

   function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] idx);
      return (idx == CW'(C - 1)) ? '0 : idx + 1'b1;
   endfunction

   logic [C-1:0]  mem_ac_q, mem_ac_d;
   logic [15:0]   mem_adr_q, mem_adr_d;
   logic [15:0]   mem_wdat_q, mem_wdat_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_re_q, mem_re_d;
   logic [CW-1:0] mem_ptr_q, mem_ptr_d;
   logic [C-1:0]  mem_last_q, mem_last_d;
   logic [C-1:0]  mem_req;
   logic [CW:0]   mem_pick;
   logic [CW-1:0] mem_win;

   logic [L-1:0]          busy_q, busy_d;
   logic [L-1:0][CW-1:0]  owner_q, owner_d;
   logic                  err_q, err_d;
   logic [C-1:0]          lock_ac_q, lock_ac_d;
   logic [CW-1:0]         lock_ptr_q, lock_ptr_d;
   logic [C-1:0]          lock_last_q, lock_last_d;
   logic [C-1:0]          lock_cand;
   logic [CW:0]           lock_pick;
   logic [CW-1:0]         lock_win;

   // The previous winner sits out exactly one arbitration.
   assign mem_req = (main_mem_read_request | main_mem_write_request) & ~mem_last_q;

   always_comb begin
      mem_pick   = rr_pick(mem_req, mem_ptr_q);
      mem_win    = mem_pick[CW-1:0];
      mem_ac_d   = '0;
      mem_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      mem_adr_d  = mem_adr_q;
      mem_wdat_d = mem_wdat_q;
      mem_ptr_d  = mem_ptr_q;
      mem_last_d = '0;
      if (mem_pick[CW]) begin
         mem_ac_d[mem_win]   = 1'b1;
         mem_last_d[mem_win] = 1'b1;
         mem_ptr_d           = wrap_inc(mem_win);
         mem_wdat_d          = wr_dat_v[mem_win];
         if (main_mem_write_request[mem_win]) begin
            mem_we_d  = 1'b1;
            mem_adr_d = wr_adr_v[mem_win];
         end else begin
            mem_re_d  = 1'b1;
            mem_adr_d = rd_adr_v[mem_win];
         end
      end
   end

   // Eligibility reads busy_q/owner_q, so an entry freed this edge is only grantable next edge.
   always_comb begin
      busy_d      = busy_q;
      owner_d     = owner_q;
      err_d       = err_q;
      lock_ac_d   = '0;
      lock_ptr_d  = lock_ptr_q;
      lock_last_d = '0;
      lock_cand   = '0;
      for (int i = 0; i < C; i++) begin
         if (unlock_en[i]) begin
            if (busy_q[lk_adr_v[i]] && owner_q[lk_adr_v[i]] == CW'(i)) begin
               busy_d[lk_adr_v[i]] = 1'b0;
               lock_ac_d[i]        = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else if (lock_en[i] && !lock_last_q[i] &&
                      (!busy_q[lk_adr_v[i]] || owner_q[lk_adr_v[i]] == CW'(i))) begin
            lock_cand[i] = 1'b1;
         end
      end
      lock_pick = rr_pick(lock_cand, lock_ptr_q);
      lock_win  = lock_pick[CW-1:0];
      if (lock_pick[CW]) begin
         busy_d[lk_adr_v[lock_win]]  = 1'b1;
         owner_d[lk_adr_v[lock_win]] = lock_win;
         lock_ac_d[lock_win]         = 1'b1;
         lock_last_d[lock_win]       = 1'b1;
         lock_ptr_d                  = wrap_inc(lock_win);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_ac_q    <= '0;
         mem_adr_q   <= '0;
         mem_wdat_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_ptr_q   <= '0;
         mem_last_q  <= '0;
         busy_q      <= '0;
         owner_q     <= '0;
         err_q       <= 1'b0;
         lock_ac_q   <= '0;
         lock_ptr_q  <= '0;
         lock_last_q <= '0;
      end else begin
         mem_ac_q    <= mem_ac_d;
         mem_adr_q   <= mem_adr_d;
         mem_wdat_q  <= mem_wdat_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         mem_ptr_q   <= mem_ptr_d;
         mem_last_q  <= mem_last_d;
         busy_q      <= busy_d;
         owner_q     <= owner_d;
         err_q       <= err_d;
         lock_ac_q   <= lock_ac_d;
         lock_ptr_q  <= lock_ptr_d;
         lock_last_q <= lock_last_d;
      end
   end

   assign main_mem_ac = mem_ac_q;
   assign mem_adr     = mem_adr_q;
   assign mem_wdat    = mem_wdat_q;
   assign mem_we      = mem_we_q;
   assign mem_re      = mem_re_q;
   assign lock_ac     = lock_ac_q;
   assign lock_busy   = busy_q;
   assign lock_err    = err_q;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Scoreboard bench for mem_lock_arbiter: a per-cycle reference model of the
// arbitration and lock rules predicts every registered output.
module tb_mem_lock_arbiter;
   localparam int C  = 8;
   localparam int L  = 16;
   localparam int LW = 4;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [C-1:0]         rd_req, wr_req;
   logic [C-1:0][15:0]   rd_adr, wr_adr, wr_dat;
   logic [C-1:0]         main_mem_ac;
   logic [15:0]          mem_adr, mem_wdat;
   logic                 mem_we, mem_re;
   logic [C-1:0][LW-1:0] lk_adr;
   logic [C-1:0]         lk_en, ul_en;
   logic [C-1:0]         lock_ac;
   logic [L-1:0]         lock_busy;
   logic                 lock_err;

   mem_lock_arbiter #(.C(C), .L(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .main_mem_read_request(rd_req), .main_mem_write_request(wr_req),
      .main_mem_read_adr(rd_adr), .main_mem_write_adr(wr_adr), .main_mem_write_dat(wr_dat),
      .main_mem_ac(main_mem_ac), .mem_adr(mem_adr), .mem_we(mem_we), .mem_re(mem_re),
      .mem_wdat(mem_wdat), .lock_adr(lk_adr), .lock_en(lk_en), .unlock_en(ul_en),
      .lock_ac(lock_ac), .lock_busy(lock_busy), .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [C-1:0] ac;
      logic         we;
      logic         re;
      logic [15:0]  adr;
      logic [15:0]  wdat;
      logic [C-1:0] lac;
      logic [L-1:0] busy;
      logic         err;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Core-side intent.
   bit          pw[C], pr[C], hold[C], lk[C], ul[C];
   logic [15:0] wa[C], wd[C], ra[C];
   int          la[C];

   // Reference state.
   int          m_ptr, m_last, l_ptr, l_last, last_win;
   bit          last_wr;
   bit          busy[L];
   int          owner[L];
   bit          err;
   logic [15:0] e_adr, e_wdat;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_last = -1; l_ptr = 0; l_last = -1; last_win = -1; last_wr = 0;
      for (int i = 0; i < L; i++) begin busy[i] = 0; owner[i] = 0; end
      err = 0; e_adr = 0; e_wdat = 0;
   endtask

   task automatic drive_pins();
      for (int i = 0; i < C; i++) begin
         rd_req[i] = pr[i]; wr_req[i] = pw[i];
         rd_adr[i] = ra[i]; wr_adr[i] = wa[i]; wr_dat[i] = wd[i];
         lk_en[i]  = lk[i]; ul_en[i]  = ul[i]; lk_adr[i] = LW'(la[i]);
      end
   endtask

   task automatic predict();
      exp_t e;
      int   win;
      bit   nb[L];
      int   no[L];
      e = '{default: '0};
      win = -1;
      for (int k = 0; k < C; k++) begin
         int i = (m_ptr + k) % C;
         if ((pw[i] || pr[i]) && i != m_last) begin win = i; break; end
      end
      last_win = win;
      if (win >= 0) begin
         e.ac[win] = 1'b1;
         last_wr   = pw[win];
         e_wdat    = wd[win];
         if (pw[win]) begin e.we = 1; e_adr = wa[win]; end
         else begin e.re = 1; e_adr = ra[win]; end
         m_ptr  = (win + 1) % C;
         m_last = win;
      end else begin
         m_last = -1;
      end
      e.adr = e_adr; e.wdat = e_wdat;

      nb = busy; no = owner;
      for (int i = 0; i < C; i++) begin
         if (ul[i]) begin
            if (busy[la[i]] && owner[la[i]] == i) begin nb[la[i]] = 0; e.lac[i] = 1'b1; end
            else err = 1;
         end
      end
      win = -1;
      for (int k = 0; k < C; k++) begin
         int i = (l_ptr + k) % C;
         if (lk[i] && !ul[i] && i != l_last && (!busy[la[i]] || owner[la[i]] == i)) begin
            win = i; break;
         end
      end
      if (win >= 0) begin
         nb[la[win]] = 1; no[la[win]] = win; e.lac[win] = 1'b1;
         l_ptr = (win + 1) % C; l_last = win;
      end else begin
         l_last = -1;
      end
      busy = nb; owner = no;
      for (int j = 0; j < L; j++) e.busy[j] = busy[j];
      e.err = err;
      q.push_back(e);
   endtask

   // One cycle: present inputs, predict the next edge, then the granted core retires its request.
   task automatic step();
      drive_pins();
      predict();
      @(negedge clk);
      if (last_win >= 0 && !hold[last_win]) begin
         if (last_wr) pw[last_win] = 0;
         else pr[last_win] = 0;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ac"}, 32'(main_mem_ac), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_re"}, 32'(mem_re), 0);
      chk({tag, "_adr"}, 32'(mem_adr), 0);
      chk({tag, "_wdat"}, 32'(mem_wdat), 0);
      chk({tag, "_lock_ac"}, 32'(lock_ac), 0);
      chk({tag, "_busy"}, 32'(lock_busy), 0);
      chk({tag, "_err"}, 32'(lock_err), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("main_mem_ac", 32'(main_mem_ac), 32'(e.ac));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_re", 32'(mem_re), 32'(e.re));
            chk("mem_adr", 32'(mem_adr), 32'(e.adr));
            chk("mem_wdat", 32'(mem_wdat), 32'(e.wdat));
            chk("lock_ac", 32'(lock_ac), 32'(e.lac));
            chk("lock_busy", 32'(lock_busy), 32'(e.busy));
            chk("lock_err", 32'(lock_err), 32'(e.err));
         end
      end
   end

   initial begin : driver
      reset_n = 1'b0;
      for (int i = 0; i < C; i++) begin
         pw[i] = 0; pr[i] = 0; hold[i] = 0; lk[i] = 0; ul[i] = 0;
         wa[i] = 0; wd[i] = 0; ra[i] = 0; la[i] = 0;
      end
      model_reset();
      drive_pins();
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Single write from core 3, then an idle cycle.
      pw[3] = 1; wa[3] = 16'h0040; wd[3] = 16'hBEEF;
      step();
      step();

      // Three continuous readers rotate, then core 5 alone.
      pr[0] = 1; ra[0] = 16'h1000; hold[0] = 1;
      pr[2] = 1; ra[2] = 16'h1002; hold[2] = 1;
      pr[5] = 1; ra[5] = 16'h1005; hold[5] = 1;
      repeat (6) step();
      pr[0] = 0; hold[0] = 0; pr[2] = 0; hold[2] = 0;
      repeat (4) step();
      pr[5] = 0; hold[5] = 0;
      step();

      // Core 1 with both read and write pending.
      pr[1] = 1; ra[1] = 16'h0010;
      pw[1] = 1; wa[1] = 16'h0020; wd[1] = 16'h1234;
      repeat (4) step();

      // Contention on lock 7, then hand-over.
      lk[0] = 1; la[0] = 7; lk[4] = 1; la[4] = 7;
      step();
      lk[0] = 0; ul[0] = 1;
      step();
      ul[0] = 0;
      step();
      lk[4] = 0;
      step();

      // Unlock by a non-owner.
      lk[1] = 1; la[1] = 2;
      step();
      lk[1] = 0; ul[6] = 1; la[6] = 2;
      step();
      ul[6] = 0;
      step();

      // Hold locks 3 and 9 with writes in flight, then reset.
      lk[2] = 1; la[2] = 3; lk[3] = 1; la[3] = 9;
      repeat (2) step();
      lk[2] = 0; lk[3] = 0;
      pw[5] = 1; wa[5] = 16'h5555; wd[5] = 16'hA5A5;
      step();
      pw[2] = 1; wa[2] = 16'h0222; wd[2] = 16'h2222;
      pw[6] = 1; wa[6] = 16'h0666; wd[6] = 16'h6666;
      drive_pins();
      #2 reset_n = 1'b0;
      #1 check_zero("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (4) step();

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < C; i++) begin
            if (!pw[i] && $urandom_range(3) == 0) begin
               pw[i] = 1; wa[i] = 16'($urandom); wd[i] = 16'($urandom);
            end
            if (!pr[i] && $urandom_range(3) == 0) begin
               pr[i] = 1; ra[i] = 16'($urandom);
            end
            lk[i] = ($urandom_range(3) == 0);
            ul[i] = ($urandom_range(9) == 0);
            la[i] = int'($urandom_range(3));
         end
         step();
      end
      for (int i = 0; i < C; i++) begin pw[i] = 0; pr[i] = 0; lk[i] = 0; ul[i] = 0; end
      repeat (3) step();
      @(posedge clk);
      #2 chk("queue_drained", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_lock_arbiter.md
Name: mem_lock_arbiter

Overview:
- Shares the single main memory port and a 16-entry hardware lock table among C cores.
- Sits between the core array and main_mem, and replaces direct wiring of per-core request/address buses.
- Issues one registered memory access per cycle. Grants one lock acquisition per cycle. Both use independent round-robin pointers.
- Memory is clocked on the falling edge, so a granted access completes within the grant cycle.

Parameters:
- C, 8, number of requesting cores (core id width = $clog2(C)).
- L, 16, number of lock entries (lock address width = $clog2(L)).

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- main_mem_read_request  in  C  per-core level read request.
- main_mem_write_request  in  C  per-core level write request.
- main_mem_read_adr  in  C x 16  per-core read address.
- main_mem_write_adr  in  C x 16  per-core write address.
- main_mem_write_dat  in  C x 16  per-core write data.
- main_mem_ac  out  C  one-hot access grant, 1-cycle pulse.
- mem_adr  out  16  address to main_mem.
- mem_we  out  1  write strobe to main_mem.
- mem_re  out  1  read strobe to main_mem.
- mem_wdat  out  16  write data to main_mem.
- lock_adr  in  C x log2(L)  per-core lock index.
- lock_en  in  C  per-core level acquire request.
- unlock_en  in  C  per-core level release request.
- lock_ac  out  C  per-core lock/unlock acknowledge, 1-cycle pulse.
- lock_busy  out  L  per-entry held flag (debug/LED).
- lock_err  out  1  sticky: unlock attempted by a non-owner.

Behaviour:
- Reset (reset_n=0, async):
  - main_mem_ac=0, lock_ac=0, mem_we=0, mem_re=0, mem_adr=0, mem_wdat=0.
  - All lock entries free (lock_busy=0), lock_err=0.
  - Both round-robin pointers = 0, both last-winner masks cleared.
  - Reset mid-access drops the access; no write is issued after reset deasserts.
- Memory arbitration, evaluated every rising edge:
  - req[i] = read_request[i] | write_request[i], with core last_mem_winner masked out.
  - The winner is the first set req at or after mem_ptr, wrapping C-1 to 0.
  - On the edge, register: main_mem_ac = onehot(winner), and mem_adr/mem_wdat/mem_we/mem_re from that core.
  - Write takes priority if a core asserts both requests. The read stays pending and is served by a later grant.
  - Latency: request sampled at edge N gives grant visible in cycle N+1; the access completes on the falling edge of cycle N+1.
  - After a grant, mem_ptr = winner+1 mod C and last_mem_winner = winner for exactly one arbitration.
  - A sole requester is therefore granted every other cycle. Cores drop or renew their request in the cycle after ac.
  - No requests: ac=0, we=0, re=0; adr and wdat hold their previous values.
- Lock table: each entry holds busy and owner[id].
- Unlock, all cores in parallel on each edge:
  - unlock_en[i] and entry lock_adr[i] busy with owner==i: free the entry, lock_ac[i]=1 next cycle.
  - Otherwise: no state change, no ack, lock_err set (sticky until reset).
  - unlock_en takes priority over lock_en on the same core in the same cycle. lock_en is ignored that cycle.
- Lock acquire, one winner per edge:
  - Candidates are cores with lock_en=1, unlock_en=0, not last_lock_winner.
  - A candidate is eligible if its entry is free, or is held with owner==self (idempotent re-ack).
  - Eligibility uses the table state before this edge's unlocks. A lock freed at edge N is grantable at edge N+1 at the earliest.
  - The winner is chosen round-robin from lock_ptr. The entry becomes busy with owner=winner, and lock_ac[winner]=1 next cycle.
  - Then lock_ptr = winner+1 and last_lock_winner = winner.
  - Ineligible requesters (held by another core) wait without ack.
- lock_busy reflects registered table state.
- Memory and lock arbitration are independent. A core may receive main_mem_ac and lock_ac in the same cycle.

Test Plan:
- Reset then core 3 write_request, write_adr=0x0040, dat=0xBEEF -> next cycle main_mem_ac=0x08, mem_we=1, mem_adr=0x0040, mem_wdat=0xBEEF; ac=0 the following cycle.
- Cores 0, 2, 5 hold read requests continuously -> grants rotate 0x01, 0x04, 0x20, 0x01, ...; core 5 held alone -> ac=0x20 every other cycle.
- Core 1 asserts both read (0x10) and write (0x20) -> first grant has mem_we=1, adr=0x20; next grant has mem_re=1, adr=0x10.
- Cores 0 and 4 lock_en on lock_adr=7 in the same cycle -> lock_ac=0x01, lock_busy[7]=1; core 4 gets no ack. Core 0 unlocks -> lock_ac=0x01 next cycle, then core 4 acked one cycle later.
- Core 6 unlock_en on lock 2 owned by core 1 -> no ack, lock_err=1, lock_busy[2] unchanged.
- reset_n pulsed low while writes pending and locks 3 and 9 held -> all outputs 0 immediately; after release the first grant goes to the lowest-index requester.
